// File: rtl/ps_reg_sequencer.sv
// ps_reg_sequencer
//   Controller for a NBITS_DATA-wide parallel/serial shift register
//   (SEL=1 shifts Din_serie in at the MSB, SEL=0 loads Din every clock).
//   It arbitrates between a parallel-load requester and a serial bit stream,
//   assembles or loads one word in the register, then presents it on a
//   valid/ready output. The register has no enable, so Din/SEL are driven in
//   every cycle; when nothing else is happening Din=reg_q so it holds.
//
// Ports
//   clk, reset                   rising-edge clock, async active-high reset
//   load_valid/load_data/load_ready   parallel load request channel
//   ser_valid/ser_bit/ser_ready       serial bit channel (first bit -> reg_q[0])
//   word_valid/word_data/word_ready   assembled word output (word_data = reg_q)
//   reg_q                        register Dout feedback
//   reg_din/reg_sel/reg_sin      register Din / SEL / Din_serie
//   busy                         high whenever the FSM is not idle
//   abort                        one-cycle pulse on a serial timeout
//
// Configuration
//   SHIFT_TIMEOUT_EN  when defined, a partially assembled serial word is
//                     discarded (register cleared, abort pulsed) after
//                     TIMEOUT_CYC consecutive SHIFT cycles without ser_valid.
//                     When undefined, SHIFT waits indefinitely and abort=0.

module ps_reg_sequencer #(
    parameter int NBITS_DATA  = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [NBITS_DATA-1:0] load_data,
    output logic                  load_ready,
    input  logic                  ser_valid,
    input  logic                  ser_bit,
    output logic                  ser_ready,
    output logic                  word_valid,
    output logic [NBITS_DATA-1:0] word_data,
    input  logic                  word_ready,
    input  logic [NBITS_DATA-1:0] reg_q,
    output logic [NBITS_DATA-1:0] reg_din,
    output logic                  reg_sel,
    output logic                  reg_sin,
    output logic                  busy,
    output logic                  abort
);

    localparam int CW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    if (NBITS_DATA < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ps_reg_sequencer: NBITS_DATA and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;

    logic            w_idle;
    logic            w_load_acc;
    logic            w_ser_acc;
    logic            w_last_bit;
    logic            w_timeout;

    assign w_idle     = (r_state == IDLE);

    // Handshakes are qualified by ~reset so nothing is accepted while the
    // register is being cleared. Load has fixed priority over serial in IDLE.
    assign w_load_acc = ~reset & w_idle & load_valid;
    assign w_ser_acc  = ~reset & ser_valid &
                        ((w_idle & ~load_valid) | (r_state == SHIFT));

    // r_count is 0 in IDLE, so with NBITS_DATA==1 the very first bit is
    // also the last one and goes straight to PRESENT.
    assign w_last_bit = (r_count == CW'(NBITS_DATA - 1));

`ifdef SHIFT_TIMEOUT_EN
    logic [IW-1:0] r_idle;

    // Fires in the TIMEOUT_CYC-th consecutive SHIFT cycle without a bit.
    assign w_timeout = ~reset & (r_state == SHIFT) & ~ser_valid &
                       (r_idle == IW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle <= '0;
        end else if (r_state != SHIFT || ser_valid || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + IW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State and bit counter. Handshake and register-control outputs are
    // combinational because the register must see Din/SEL in the same cycle
    // that the request is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_load_acc) begin
                        r_state <= PRESENT;
                    end else if (w_ser_acc) begin
                        if (w_last_bit) begin
                            r_state <= PRESENT;
                            r_count <= '0;
                        end else begin
                            r_state <= SHIFT;
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (w_ser_acc) begin
                        if (w_last_bit) begin
                            r_state <= PRESENT;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (word_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Register control: hold by default (Din = Dout, SEL = 0).
    always_comb begin
        reg_din = reg_q;
        reg_sel = 1'b0;
        reg_sin = ser_bit;
        if (w_timeout) begin
            reg_din = '0;
        end else if (w_load_acc) begin
            reg_din = load_data;
        end else if (w_ser_acc) begin
            reg_sel = 1'b1;
        end
    end

    assign load_ready = ~reset & w_idle;
    assign ser_ready  = ~reset & ((w_idle & ~load_valid) | (r_state == SHIFT));
    assign word_valid = ~reset & (r_state == PRESENT);
    assign busy       = ~reset & ~w_idle;
    assign abort      = w_timeout;
    assign word_data  = reg_q;

endmodule

// File: tb/tb_ps_reg_sequencer.sv
module tb_ps_reg_sequencer;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [N-1:0] load_data;
    logic         load_ready;
    logic         ser_valid;
    logic         ser_bit;
    logic         ser_ready;
    logic         word_valid;
    logic [N-1:0] word_data;
    logic         word_ready;
    logic [N-1:0] reg_q;
    logic [N-1:0] reg_din;
    logic         reg_sel;
    logic         reg_sin;
    logic         busy;
    logic         abort;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps_reg_sequencer #(
        .NBITS_DATA (N),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_ready (ser_ready),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_ready(word_ready),
        .reg_q     (reg_q),
        .reg_din   (reg_din),
        .reg_sel   (reg_sel),
        .reg_sin   (reg_sin),
        .busy      (busy),
        .abort     (abort)
    );

    // The controlled parallel/serial register (environment, not the DUT).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        reg_q <= '0;
        else if (reg_sel) reg_q <= {reg_sin, reg_q[N-1:1]};
        else              reg_q <= reg_din;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [N-1:0] ld, input logic sv,
                         input logic sb, input logic wr);
        load_valid = lv;
        load_data  = ld;
        ser_valid  = sv;
        ser_bit    = sb;
        word_ready = wr;
        #2;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic consume(input logic [N-1:0] expw, input string nm);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk({nm, "_wv"}, word_valid, 1);
        chk({nm, "_wd"}, word_data, expw);
        next();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_idle_wv"}, word_valid, 0);
        chk({nm, "_idle_lr"}, load_ready, 1);
    endtask

    task automatic send_bit(input logic b, input string nm);
        drive(1'b0, '0, 1'b1, b, 1'b0);
        chk({nm, "_sr"}, ser_ready, 1);
        chk({nm, "_sel"}, reg_sel, 1);
        chk({nm, "_sin"}, reg_sin, b);
        next();
    endtask

    typedef struct {
        logic         lv;
        logic [N-1:0] ld;
        logic         sv;
        logic         sb;
        logic         e_lr;
        logic         e_sr;
        logic         e_sel;
        logic [N-1:0] e_din;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] expw;
        logic         sv_pat [6];
        logic         sb_pat [6];

        tbl[0] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0};
        tbl[2] = '{1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0};
        tbl[3] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5};
        tbl[4] = '{1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC};
        tbl[5] = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};

        // ---- reset with both requesters active
        reset = 1'b1;
        drive(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
        chk("rst_lr", load_ready, 0);
        chk("rst_sr", ser_ready, 0);
        chk("rst_wv", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        next();
        next();
        chk("rst_lr2", load_ready, 0);
        chk("rst_sr2", ser_ready, 0);
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_lr", load_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_q", reg_q, 0);

        // ---- IDLE arbitration table (inputs withdrawn before each edge)
        for (int i = 0; i < 6; i++) begin
            next();
            drive(tbl[i].lv, tbl[i].ld, tbl[i].sv, tbl[i].sb, 1'b0);
            chk($sformatf("tbl%0d_lr", i), load_ready, tbl[i].e_lr);
            chk($sformatf("tbl%0d_sr", i), ser_ready, tbl[i].e_sr);
            chk($sformatf("tbl%0d_sel", i), reg_sel, tbl[i].e_sel);
            chk($sformatf("tbl%0d_din", i), reg_din, tbl[i].e_din);
            if (tbl[i].e_sel) chk($sformatf("tbl%0d_sin", i), reg_sin, tbl[i].sb);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
        chk("tbl_still_idle", busy, 0);

        // ---- parallel load 4'hA, word_ready low for 3 cycles
        next();
        drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("pl_lr", load_ready, 1);
        chk("pl_din", reg_din, 4'hA);
        chk("pl_sel", reg_sel, 0);
        next();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("pl_wv", word_valid, 1);
        chk("pl_wd", word_data, 4'hA);
        chk("pl_busy", busy, 1);
        chk("pl_lr0", load_ready, 0);
        chk("pl_sr0", ser_ready, 0);
        for (int k = 0; k < 3; k++) begin
            next();
            drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
            chk("pl_hold_wv", word_valid, 1);
            chk("pl_hold_wd", word_data, 4'hA);
            chk("pl_hold_din", reg_din, 4'hA);
            chk("pl_hold_sel", reg_sel, 0);
        end
        consume(4'hA, "pl");

        // ---- serial 1,0,(gap 2),1,1 -> 4'hD
        sv_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        sb_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        next();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, sv_pat[i], sb_pat[i], 1'b0);
            chk($sformatf("ser%0d_sr", i), ser_ready, 1);
            chk($sformatf("ser%0d_sel", i), reg_sel, sv_pat[i]);
            if (sv_pat[i]) chk($sformatf("ser%0d_sin", i), reg_sin, sb_pat[i]);
            if (i < 5) chk($sformatf("ser%0d_wv", i), word_valid, 0);
            next();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("ser_wv", word_valid, 1);
        chk("ser_wd", word_data, 4'hD);
        chk("ser_sr0", ser_ready, 0);
        consume(4'hD, "ser");

        // ---- arbitration: load 4'h3 against a serial bit
        next();
        drive(1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
        chk("arb_sr", ser_ready, 0);
        chk("arb_lr", load_ready, 1);
        chk("arb_sel", reg_sel, 0);
        chk("arb_din", reg_din, 4'h3);
        next();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("arb_wv", word_valid, 1);
        chk("arb_wd", word_data, 4'h3);
        consume(4'h3, "arb");

        // ---- mid-operation reset after 2 bits, then 0,1,1,0 -> 4'h6
        next();
        send_bit(1'b1, "mr_b0");
        send_bit(1'b1, "mr_b1");
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("mr_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("mr_busy_rst", busy, 0);
        chk("mr_q_rst", reg_q, 0);
        reset = 1'b0;
        #1;
        chk("mr_lr", load_ready, 1);
        chk("mr_busy", busy, 0);
        next();
        send_bit(1'b0, "mr_n0");
        send_bit(1'b1, "mr_n1");
        send_bit(1'b1, "mr_n2");
        send_bit(1'b0, "mr_n3");
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("mr_wv", word_valid, 1);
        chk("mr_wd", word_data, 4'h6);
        consume(4'h6, "mr");

        // ---- serial timeout: one bit, then TO idle cycles
        next();
        send_bit(1'b1, "to_b0");
        for (int i = 1; i <= TO; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef SHIFT_TIMEOUT_EN
            chk($sformatf("to_abort%0d", i), abort, (i == TO) ? 1 : 0);
            if (i == TO) chk("to_din", reg_din, 0);
`else
            chk($sformatf("to_abort%0d", i), abort, 0);
`endif
            chk($sformatf("to_busy%0d", i), busy, 1);
            next();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("to_abort_after", abort, 0);
`ifdef SHIFT_TIMEOUT_EN
        chk("to_busy_after", busy, 0);
        chk("to_q", reg_q, 0);
        chk("to_lr", load_ready, 1);
`else
        chk("to_busy_after", busy, 1);
        chk("to_lr", load_ready, 0);
        next();
        send_bit(1'b0, "to_b1");
        send_bit(1'b0, "to_b2");
        send_bit(1'b1, "to_b3");
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("to_wv", word_valid, 1);
        chk("to_wd", word_data, 4'h9);
        consume(4'h9, "to");
`endif

        // ---- randomized transactions against a word-level model
        for (int t = 0; t < 40; t++) begin
            next();
            if ($urandom_range(0, 1) == 1) begin
                logic [N-1:0] d;
                d = N'($urandom_range(0, 15));
                drive(1'b1, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                chk("rnd_load_lr", load_ready, 1);
                chk("rnd_load_sr", ser_ready, 0);
                chk("rnd_load_sel", reg_sel, 0);
                next();
                expw = d;
            end else begin
                expw = '0;
                for (int i = 0; i < N; i++) begin
                    int gap;
                    logic b;
                    gap = int'($urandom_range(0, 2));
                    for (int g = 0; g < gap; g++) begin
                        // load requests are ignored once a word is in progress
                        drive((i > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                              N'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
                        chk("rnd_gap_sel", reg_sel, 0);
                        if (i > 0) chk("rnd_gap_lr", load_ready, 0);
                        next();
                    end
                    b = 1'($urandom_range(0, 1));
                    drive((i > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                          N'($urandom_range(0, 15)), 1'b1, b, 1'b0);
                    chk("rnd_bit_sr", ser_ready, 1);
                    chk("rnd_bit_sel", reg_sel, 1);
                    next();
                    expw = expw | (N'(b) << i);
                end
            end
            for (int w = int'($urandom_range(0, 3)); w > 0; w--) begin
                drive(1'($urandom_range(0, 1)), N'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                chk("rnd_hold_wv", word_valid, 1);
                chk("rnd_hold_wd", word_data, expw);
                chk("rnd_hold_lr", load_ready, 0);
                chk("rnd_hold_sr", ser_ready, 0);
                next();
            end
            consume(expw, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps_reg_sequencer.md
Name: ps_reg_sequencer

Overview:
Controller for the 4-bit parallel/serial shift register (SEL=1 shifts Din_serie in at the MSB; SEL=0 loads Din every clock). The register has no enable, so this block drives it every cycle. It arbitrates between a parallel-load requester and a serial bit stream, assembles or loads one word, then presents that word on a valid/ready output. It sits between the upstream producers and the register instance, and owns the register's Din, SEL and Din_serie.

Parameters:
NBITS_DATA, 4, register and word width; must match the controlled register.
TIMEOUT_CYC, 8, idle-cycle limit for an in-progress serial word (used only with SHIFT_TIMEOUT_EN).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load_valid  input  1  parallel load request
load_data  input  NBITS_DATA  word to load
load_ready  output  1  load accepted when load_valid & load_ready
ser_valid  input  1  serial bit available
ser_bit  input  1  serial bit value
ser_ready  output  1  bit accepted when ser_valid & ser_ready
word_valid  output  1  assembled or loaded word available
word_data  output  NBITS_DATA  equals reg_q
word_ready  input  1  consumer accepts word
reg_q  input  NBITS_DATA  register Dout feedback
reg_din  output  NBITS_DATA  to register Din
reg_sel  output  1  to register SEL
reg_sin  output  1  to register Din_serie
busy  output  1  high when state != IDLE
abort  output  1  one-cycle pulse on serial timeout

Behaviour:
- FSM has 3 states: IDLE, SHIFT and PRESENT. A bit counter counts 0..NBITS_DATA-1.
- Reset (async) forces state=IDLE and count=0.
- While reset is asserted, all handshake outputs are 0: load_ready, ser_ready, word_valid, busy, abort.
- reg_sel=0 and reg_din=reg_q are driven in every cycle that does not override them below, so the register holds its value.
- IDLE:
  - load_ready=1.
  - ser_ready=~load_valid. A parallel load has fixed priority over a serial bit.
- IDLE, load handshake:
  - reg_din=load_data and reg_sel=0 in that cycle.
  - Next state is PRESENT. word_valid=1 in the next cycle, with word_data equal to the loaded value.
- IDLE, serial handshake (ser_valid & ~load_valid):
  - reg_sel=1 and reg_sin=ser_bit in that cycle.
  - count becomes 1 and the next state is SHIFT. If NBITS_DATA==1, the next state is PRESENT instead.
- SHIFT:
  - load_ready=0 and ser_ready=1.
  - Each accepted bit drives reg_sel=1 and reg_sin=ser_bit, and increments count.
  - When the bit at count==NBITS_DATA-1 is accepted, count returns to 0 and the next state is PRESENT.
  - Cycles without ser_valid hold the register.
- Bit order: the first bit accepted ends at reg_q[0], and the last bit accepted ends at reg_q[NBITS_DATA-1].
- PRESENT:
  - word_valid=1, word_data=reg_q, and the register holds.
  - load_ready=0 and ser_ready=0.
  - On word_ready, the next state is IDLE. A new request can be accepted no earlier than the following cycle.
- word_data is always reg_q. It is meaningful only while word_valid=1.
- Reset in mid-operation discards any partial word and returns to IDLE. The register is cleared by the same reset.

Optional Feature:
SHIFT_TIMEOUT_EN:
- Defined: an idle counter counts consecutive SHIFT cycles without ser_valid, and any accepted bit clears it. When the counter reaches TIMEOUT_CYC:
  - reg_din=0 and reg_sel=0 in that cycle, which clears the register.
  - abort=1 for exactly that cycle.
  - count=0 and the next state is IDLE.
- Not defined: there is no timeout, SHIFT waits indefinitely, and abort is tied to 0.

Test Plan:
- Reset: assert reset while load_valid=1 and ser_valid=1. Required: all handshake outputs are 0. After release: state=IDLE, load_ready=1, busy=0.
- Parallel load: load_data=4'hA with a load handshake. Required: next cycle word_valid=1 and word_data=4'hA. With word_ready held low for 3 cycles, the data is stable and reg_din=reg_q. On word_ready=1, the block returns to IDLE.
- Serial assembly: bits 1,0,1,1 on consecutive cycles, with a 2-cycle ser_valid gap after the second bit. Required: reg_sel=1 only on accepted cycles, and word_valid rises after the 4th bit with word_data=4'hD.
- Arbitration: load_valid=1 (data 4'h3) and ser_valid=1 in the same IDLE cycle. Required: ser_ready=0, the load wins, word_data=4'h3, and the serial bit is not consumed.
- Mid-operation reset: pulse reset after 2 serial bits. Required: IDLE, reg_q=0, and a fresh 4-bit sequence 0,1,1,0 yields 4'h6.
- Timeout (SHIFT_TIMEOUT_EN, TIMEOUT_CYC=8): 1 bit then 8 idle cycles. Required: a one-cycle abort pulse, reg_q=0, IDLE. Without the macro, abort stays 0 and the block stays in SHIFT.
